// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared types and constants for the UART FIFO read-side control logic.
package uart_fifo_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, POP, DELIVER} arb_state_t;

  localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Upper segment (above last) has priority over the wrapped lower segment.
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        gnt[i] = 1'b1;
        idx    = IdxW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        gnt[i] = 1'b1;
        idx    = IdxW'(i);
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/uart_rx_fifo_arbiter.sv
// Shares the UART RX FIFO read port between NUM_REQ consumers: round-robin pick,
// single-cycle pop, byte capture and valid/ack hand-off with optional ack timeout.
module uart_rx_fifo_arbiter
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [NUM_REQ-1:0]   Rd_Ack,
  input  logic                 FIFO_Empty,
  input  logic                 Data_Rdy,
  input  logic                 BIST_Mode,
  input  logic [DATA_BITS-1:0] Fifo_Data,
  output logic                 Pop_Data,
  output logic [NUM_REQ-1:0]   Grant,
  output logic                 Rd_Valid,
  output logic [DATA_BITS-1:0] Rd_Data,
  output logic                 Timeout,
  output logic                 Busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 pop_q, pop_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tmo_q, tmo_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [IdxW-1:0]      win_q, win_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 start;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req  (Req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Never launch a pop while the receiver is writing: the FIFO would drop it.
  assign start = pick_any && !FIFO_Empty && !Data_Rdy && !BIST_Mode;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pop_d   = pop_q;
    valid_d = valid_q;
    data_d  = data_q;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = POP;
          grant_d = pick_gnt;
          win_d   = pick_idx;
          pop_d   = 1'b1;
        end
      end
      POP: begin
        pop_d   = 1'b0;
        data_d  = Fifo_Data;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = DELIVER;
      end
      DELIVER: begin
        if (Rd_Ack[win_q]) begin
          valid_d = 1'b0;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == TmoLast)) begin
          tmo_d   = 1'b1;
          valid_d = 1'b0;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      pop_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pop_q   <= pop_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign Pop_Data = pop_q;
  assign Grant    = grant_q;
  assign Rd_Valid = valid_q;
  assign Rd_Data  = data_q;
  assign Timeout  = tmo_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_arbiter.sv
// Bench for uart_rx_fifo_arbiter: FIFO model, transaction-level reference model,
// directed scenarios plus randomized traffic, all checked every cycle.
module tb_uart_rx_fifo_arbiter;

  localparam int NumReq     = 2;
  localparam int AckTimeout = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        Req = '0;
  logic [1:0]        Rd_Ack = '0;
  logic              FIFO_Empty = 1'b1;
  logic              Data_Rdy = 1'b0;
  logic              BIST_Mode = 1'b0;
  logic [7:0]        Fifo_Data = '0;
  logic              Pop_Data;
  logic [1:0]        Grant;
  logic              Rd_Valid;
  logic [7:0]        Rd_Data;
  logic              Timeout;
  logic              Busy;

  always #5 clk = ~clk;

  uart_rx_fifo_arbiter #(
    .DATA_BITS   (8),
    .NUM_REQ     (NumReq),
    .ACK_TIMEOUT (AckTimeout)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Req        (Req),
    .Rd_Ack     (Rd_Ack),
    .FIFO_Empty (FIFO_Empty),
    .Data_Rdy   (Data_Rdy),
    .BIST_Mode  (BIST_Mode),
    .Fifo_Data  (Fifo_Data),
    .Pop_Data   (Pop_Data),
    .Grant      (Grant),
    .Rd_Valid   (Rd_Valid),
    .Rd_Data    (Rd_Data),
    .Timeout    (Timeout),
    .Busy       (Busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // FIFO model
  logic [7:0] fifo_q[$];
  logic [7:0] wr_byte = '0;
  logic [7:0] last_popped = '0;
  logic       pop_prev = 1'b0;

  // Transaction model: m_age < 0 idle, 0 = pop cycle, k >= 1 = k-th delivery cycle
  int         m_age = -1;
  int         m_win = 0;
  int         m_last = NumReq - 1;
  logic [7:0] m_byte = '0;
  logic       m_tmo = 1'b0;

  logic [1:0] dlv_grant[$];
  logic [7:0] dlv_data[$];
  logic       valid_prev = 1'b0;
  int         pop_hi = 0;
  int         pop_lo = 100;
  logic       auto_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit found;
    int c;
    if (!rst_n) begin
      m_age  = -1;
      m_win  = 0;
      m_last = NumReq - 1;
      m_byte = '0;
      m_tmo  = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_age < 0) begin
        if (Req != 0 && !FIFO_Empty && !Data_Rdy && !BIST_Mode) begin
          found = 1'b0;
          for (int k = 1; k <= NumReq; k++) begin
            c = (m_last + k) % NumReq;
            if (!found && Req[c]) begin
              m_win = c;
              m_age = 0;
              found = 1'b1;
            end
          end
        end
      end else if (m_age == 0) begin
        m_age  = 1;
        m_byte = last_popped;
      end else if (Rd_Ack[m_win]) begin
        m_last = m_win;
        m_age  = -1;
      end else if (AckTimeout != 0 && m_age == AckTimeout) begin
        m_tmo  = 1'b1;
        m_last = m_win;
        m_age  = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic fifo_step();
    if (!rst_n) begin
      fifo_q.delete();
      pop_prev = 1'b0;
    end else begin
      if (Pop_Data && !pop_prev) begin
        check("pop_collision", 32'(Data_Rdy), 32'd0);
        check("pop_underflow", 32'(fifo_q.size() == 0), 32'd0);
        if (!Data_Rdy && fifo_q.size() != 0) begin
          Fifo_Data   = fifo_q.pop_front();
          last_popped = Fifo_Data;
        end
      end
      pop_prev = Pop_Data;
      if (Data_Rdy) fifo_q.push_back(wr_byte);
    end
    FIFO_Empty = (fifo_q.size() == 0);
  endtask

  task automatic compare();
    check("Pop_Data", 32'(Pop_Data), 32'(m_age == 0));
    check("Grant", 32'(Grant), (m_age >= 0) ? (32'd1 << m_win) : 32'd0);
    check("Rd_Valid", 32'(Rd_Valid), 32'(m_age >= 1));
    check("Rd_Data", 32'(Rd_Data), 32'(m_byte));
    check("Timeout", 32'(Timeout), 32'(m_tmo));
    check("Busy", 32'(Busy), 32'(m_age >= 0));
    if (Pop_Data) begin
      if (pop_hi == 0) check("pop_low_gap", 32'(pop_lo >= 2), 32'd1);
      pop_hi++;
      pop_lo = 0;
    end else begin
      if (pop_hi != 0) check("pop_width", 32'(pop_hi), 32'd1);
      pop_hi = 0;
      pop_lo++;
    end
    if (Rd_Valid && !valid_prev) begin
      dlv_grant.push_back(Grant);
      dlv_data.push_back(Rd_Data);
    end
    valid_prev = Rd_Valid;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 fifo_step();
    #3 compare();
    @(negedge clk);
    if (auto_ack) Rd_Ack = Rd_Valid ? Grant : 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pop", 32'(Pop_Data), 32'd0);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_valid", 32'(Rd_Valid), 32'd0);
    check("rst_data", 32'(Rd_Data), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    model_step();
    pop_hi     = 0;
    pop_lo     = 100;
    valid_prev = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    Data_Rdy = 1'b1;
    wr_byte  = b;
    tick();
    Data_Rdy = 1'b0;
  endtask

  task automatic check_dlv(input string name, input int idx, input logic [1:0] g,
                           input logic [7:0] d);
    logic [31:0] ag, ad;
    ag = (idx < dlv_grant.size()) ? 32'(dlv_grant[idx]) : 32'hFFFF_FFFF;
    ad = (idx < dlv_data.size()) ? 32'(dlv_data[idx]) : 32'hFFFF_FFFF;
    check({name, "_grant"}, ag, 32'(g));
    check({name, "_data"}, ad, 32'(d));
  endtask

  initial begin
    logic [7:0] t3_bytes[4];
    t3_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    do_reset();

    // Three bytes, both requesting, immediate acks: grants alternate starting at 0
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    dlv_grant.delete();
    dlv_data.delete();
    Req = 2'b11;
    auto_ack = 1'b1;
    repeat (12) tick();
    Req = 2'b00;
    check("t1_count", 32'(dlv_grant.size()), 32'd3);
    check_dlv("t1_0", 0, 2'b01, 8'hA1);
    check_dlv("t1_1", 1, 2'b10, 8'hB2);
    check_dlv("t1_2", 2, 2'b01, 8'hC3);

    // Empty FIFO holds off pops; one write gives Rd_Valid two cycles later
    auto_ack = 1'b0;
    Req = 2'b01;
    repeat (5) tick();
    check("t2_busy_idle", 32'(Busy), 32'd0);
    check("t2_no_pop", 32'(Pop_Data), 32'd0);
    write_byte(8'h5A);
    tick();
    check("t2_pop", 32'(Pop_Data), 32'd1);
    tick();
    check("t2_valid", 32'(Rd_Valid), 32'd1);
    check("t2_data", 32'(Rd_Data), 32'h5A);
    auto_ack = 1'b1;
    Rd_Ack = Grant;
    repeat (3) tick();
    Req = 2'b00;

    // Data_Rdy high for 3 cycles blocks the pop; no write is lost
    write_byte(8'h11);
    dlv_grant.delete();
    dlv_data.delete();
    Req = 2'b01;
    Data_Rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wr_byte = t3_bytes[i];
      tick();
      check("t3_no_pop", 32'(Pop_Data), 32'd0);
    end
    Data_Rdy = 1'b0;
    tick();
    check("t3_pop_after", 32'(Pop_Data), 32'd1);
    repeat (16) tick();
    Req = 2'b00;
    check("t3_count", 32'(dlv_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_dlv("t3", i, 2'b01, t3_bytes[i]);

    // Ack timeout: no ack from the winner (a stray ack from the other is ignored)
    auto_ack = 1'b0;
    Rd_Ack = 2'b00;
    write_byte(8'h77);
    write_byte(8'h88);
    Req = 2'b11;
    for (int k = 0; k < 10 && !Rd_Valid; k++) tick();
    check("t4_valid", 32'(Rd_Valid), 32'd1);
    check("t4_grant", 32'(Grant), 32'd2);
    check("t4_data", 32'(Rd_Data), 32'h77);
    Rd_Ack = 2'b01;
    repeat (3) begin
      tick();
      check("t4_no_timeout", 32'(Timeout), 32'd0);
    end
    tick();
    check("t4_timeout", 32'(Timeout), 32'd1);
    check("t4_grant_clr", 32'(Grant), 32'd0);
    check("t4_valid_clr", 32'(Rd_Valid), 32'd0);
    Rd_Ack = 2'b00;
    for (int k = 0; k < 5 && !Pop_Data; k++) tick();
    check("t4_next_grant", 32'(Grant), 32'd1);
    auto_ack = 1'b1;
    repeat (6) tick();
    Req = 2'b00;

    // BIST raised during POP: current byte completes, then nothing until BIST drops
    write_byte(8'hAA);
    write_byte(8'hBB);
    dlv_grant.delete();
    dlv_data.delete();
    Req = 2'b01;
    for (int k = 0; k < 5 && !Pop_Data; k++) tick();
    check("t5_pop", 32'(Pop_Data), 32'd1);
    BIST_Mode = 1'b1;
    repeat (8) tick();
    check("t5_one_dlv", 32'(dlv_data.size()), 32'd1);
    check_dlv("t5_0", 0, 2'b01, 8'hAA);
    check("t5_busy", 32'(Busy), 32'd0);
    BIST_Mode = 1'b0;
    repeat (6) tick();
    check("t5_two_dlv", 32'(dlv_data.size()), 32'd2);
    check_dlv("t5_1", 1, 2'b01, 8'hBB);
    Req = 2'b00;

    // Reset in DELIVER, then requester 0 wins first even though it won last
    auto_ack = 1'b0;
    Rd_Ack = 2'b00;
    write_byte(8'hCC);
    Req = 2'b01;
    for (int k = 0; k < 6 && !Rd_Valid; k++) tick();
    check("t6_valid", 32'(Rd_Valid), 32'd1);
    do_reset();
    Req = 2'b11;
    write_byte(8'hDD);
    for (int k = 0; k < 5 && !Pop_Data; k++) tick();
    check("t6_first_grant", 32'(Grant), 32'd1);
    auto_ack = 1'b1;
    repeat (4) tick();
    Req = 2'b00;

    // Randomized traffic against the model
    auto_ack = 1'b0;
    for (int i = 0; i < 800; i++) begin
      Req       = 2'($urandom);
      Data_Rdy  = ($urandom_range(0, 3) == 0);
      wr_byte   = 8'($urandom);
      BIST_Mode = ($urandom_range(0, 15) == 0);
      Rd_Ack    = ($urandom_range(0, 2) == 0) ? Grant : 2'($urandom);
      if (i == 400) do_reset();
      tick();
    end
    Req = 2'b00;
    Data_Rdy = 1'b0;
    BIST_Mode = 1'b0;
    auto_ack = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
